// File: rtl/mux_operand_sequencer_pkg.sv
// Shared constants, state encoding and width helper for the mux operand sequencer.
package mux_operand_sequencer_pkg;
  localparam int DW_DEF    = 3;
  localparam int SW_DEF    = 2;
  localparam int DEPTH_DEF = 4;
  localparam int HOLD_DEF  = 10;
  localparam int CNT_W     = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_operand_sequencer_if.sv
// Operand-pair input channel: valid/ready handshake carrying din0/din1.
interface mux_operand_sequencer_if
  import mux_operand_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_din0;
  logic [DW-1:0] in_din1;

  modport master (output in_valid, output in_din0, output in_din1, input in_ready);
  modport slave  (input in_valid, input in_din0, input in_din1, output in_ready);
endinterface

// File: rtl/mux_operand_sequencer_fifo.sv
// DEPTH x W synchronous FIFO with flush; head word is visible combinationally.
module mux_operand_sequencer_fifo
  import mux_operand_sequencer_pkg::*;
#(
  parameter int W     = 2 * DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/mux_operand_sequencer.sv
// Buffers operand pairs and sweeps sel 0..2**SW-1 over each, holding every code HOLD cycles.
module mux_operand_sequencer
  import mux_operand_sequencer_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int SW    = SW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int HOLD  = HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_operand_sequencer_if.slave op,
  input  logic                 enable,
  input  logic                 flush,
  output logic [DW-1:0]        din0,
  output logic [DW-1:0]        din1,
  output logic [SW-1:0]        sel,
  output logic                 busy,
  output logic                 step_last,
  output logic                 pair_done,
  output logic [CNT_W-1:0]     pair_cnt
);
  localparam int            HW        = cnt_width(HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [SW-1:0] SEL_MAX   = '1;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q;
  logic [2*DW-1:0] head;
  logic            full, empty, push, pop;

  assign op.in_ready = !full && !flush;
  assign push        = op.in_valid && op.in_ready;
  assign busy        = (state_q == S_RUN);
  assign step_last   = busy && (hold_q == HOLD_LAST);
  assign pair_done   = step_last && (sel == SEL_MAX);

  mux_operand_sequencer_fifo #(.W(2*DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({op.in_din0, op.in_din1}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A new pair is taken either from IDLE or on the final cycle of a sweep, so consecutive pairs run without a bubble.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable && !empty) begin
            pop     = 1'b1;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (pair_done) begin
            if (enable && !empty) pop     = 1'b1;
            else                  state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // sel stays at its last code when the sweep ends into IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din0   <= '0;
      din1   <= '0;
      sel    <= '0;
      hold_q <= '0;
    end else if (flush) begin
      din0   <= '0;
      din1   <= '0;
      sel    <= '0;
      hold_q <= '0;
    end else if (pop) begin
      {din0, din1} <= head;
      sel          <= '0;
      hold_q       <= '0;
    end else if (busy) begin
      if (step_last) begin
        hold_q <= '0;
        if (sel != SEL_MAX) sel <= sel + SW'(1);
      end else begin
        hold_q <= hold_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pair_cnt <= '0;
    else if (pair_done) pair_cnt <= pair_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_mux_operand_sequencer.sv
// Scoreboard bench: issued pairs queue up, a negedge monitor replays each expected sweep.
module tb_mux_operand_sequencer;
  import mux_operand_sequencer_pkg::*;

  localparam int DW = 3, SW = 2, DEPTH = 4, HOLD = 10;
  localparam int NS = (1 << SW) * HOLD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_operand_sequencer_if #(.DW(DW)) ifc ();
  mux_operand_sequencer_if #(.DW(DW)) h1if ();

  logic          enable, flush;
  logic [DW-1:0] din0, din1;
  logic [SW-1:0] sel;
  logic          busy, step_last, pair_done;
  logic [7:0]    pair_cnt;

  logic          h1_enable, h1_flush;
  logic [DW-1:0] h1_din0, h1_din1;
  logic [SW-1:0] h1_sel;
  logic          h1_busy, h1_step_last, h1_pair_done;
  logic [7:0]    h1_pair_cnt;

  mux_operand_sequencer #(.DW(DW), .SW(SW), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .op(ifc), .enable(enable), .flush(flush),
    .din0(din0), .din1(din1), .sel(sel), .busy(busy), .step_last(step_last),
    .pair_done(pair_done), .pair_cnt(pair_cnt)
  );

  mux_operand_sequencer #(.DW(DW), .SW(SW), .DEPTH(DEPTH), .HOLD(1)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .op(h1if), .enable(h1_enable), .flush(h1_flush),
    .din0(h1_din0), .din1(h1_din1), .sel(h1_sel), .busy(h1_busy), .step_last(h1_step_last),
    .pair_done(h1_pair_done), .pair_cnt(h1_pair_cnt)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    time           t;
  } ent_t;

  ent_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  time  flush_t = 0;
  bit   en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus on the main DUT; accepted pairs go to the scoreboard.
  task automatic tick(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit fl);
    bit acc;
    @(negedge clk);
    #1;
    ifc.in_valid = v;
    ifc.in_din0  = a;
    ifc.in_din1  = b;
    flush        = fl;
    enable       = en;
    #3;
    acc = v && ifc.in_ready;
    if (rst_n) chk("in_ready", int'(ifc.in_ready), int'((sbq.size() < DEPTH) && !fl));
    @(posedge clk);
    if (fl) begin
      sbq.delete();
      flush_t = $time;
    end else if (acc) begin
      sbq.push_back('{a: a, b: b, t: $time});
    end
  endtask

  task automatic idle_wait(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick(1'b0, '0, '0, 1'b0);
      #1;
      if (sbq.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 1, 0);
  endtask

  task automatic wait_sel(input logic [SW-1:0] s);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick(1'b0, '0, '0, 1'b0);
      #1;
      if (busy && sel == s) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("sel_timeout", 1, 0);
  endtask

  // Reference: each popped pair yields NS cycles; sel = cycle/HOLD, the last cycle of each code is step_last.
  int            idx = 0;
  logic [7:0]    mcnt = '0;
  logic [DW-1:0] ed0 = '0, ed1 = '0;
  logic [SW-1:0] esel = '0;
  ent_t          cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      idx = 0; mcnt = '0; ed0 = '0; ed1 = '0; esel = '0;
    end else if (flush_t == $time - 5) begin
      chk("flush_busy", int'(busy), 0);
      chk("flush_sel", int'(sel), 0);
      chk("flush_din0", int'(din0), 0);
      chk("flush_din1", int'(din1), 0);
      chk("flush_pair_cnt", int'(pair_cnt), int'(mcnt));
      idx = 0; ed0 = '0; ed1 = '0; esel = '0;
    end else if (busy) begin
      if (idx == 0) begin
        if (sbq.size() == 0 || sbq[0].t >= $time - 5) chk("start_without_pair", 1, 0);
        else begin
          cur = sbq.pop_front();
          ed0 = cur.a;
          ed1 = cur.b;
        end
        if (!enable) chk("start_without_enable", 1, 0);
      end
      esel = SW'(idx / HOLD);
      chk("din0", int'(din0), int'(ed0));
      chk("din1", int'(din1), int'(ed1));
      chk("sel", int'(sel), int'(esel));
      chk("step_last", int'(step_last), int'((idx % HOLD) == HOLD - 1));
      chk("pair_done", int'(pair_done), int'(idx == NS - 1));
      chk("pair_cnt", int'(pair_cnt), int'(mcnt));
      if (idx == NS - 1) mcnt = mcnt + 8'd1;
      idx = (idx + 1) % NS;
    end else begin
      chk("sweep_cut", idx, 0);
      idx = 0;
      chk("idle_step_last", int'(step_last), 0);
      chk("idle_pair_done", int'(pair_done), 0);
      chk("idle_sel", int'(sel), int'(esel));
      chk("idle_din0", int'(din0), int'(ed0));
      chk("idle_din1", int'(din1), int'(ed1));
      chk("idle_pair_cnt", int'(pair_cnt), int'(mcnt));
      if (enable && sbq.size() > 0 && sbq[0].t < $time - 5) chk("stall", 1, 0);
    end
  end

  // HOLD=1 instance: sel advances every busy cycle with step_last constantly high.
  bit h1_on = 1'b0;
  int h1_idx = 0;
  int h1_acc = 0;

  always @(negedge clk) begin
    if (h1_on && rst_n && h1_busy) begin
      chk("h1_step_last", int'(h1_step_last), 1);
      chk("h1_sel", int'(h1_sel), h1_idx % 4);
      chk("h1_pair_done", int'(h1_pair_done), int'((h1_idx % 4) == 3));
      if (h1_idx % 4 == 0) chk("h1_data", int'(h1_din1), int'(DW'(~h1_din0)));
      h1_idx++;
    end
  end

  task automatic h1tick(input bit v, input bit e);
    logic [DW-1:0] a;
    @(negedge clk);
    #1;
    a = DW'(h1_acc);
    h1if.in_valid = v;
    h1if.in_din0  = a;
    h1if.in_din1  = ~a;
    h1_enable     = e;
    #3;
    if (v && h1if.in_ready) h1_acc++;
    @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    ifc.in_valid = 1'b0; ifc.in_din0 = '0; ifc.in_din1 = '0;
    enable = 1'b0; flush = 1'b0;
    h1if.in_valid = 1'b0; h1if.in_din0 = '0; h1if.in_din1 = '0;
    h1_enable = 1'b0; h1_flush = 1'b0;
    #2;
    chk("rst_in_ready", int'(ifc.in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_din0", int'(din0), 0);
    chk("rst_pair_cnt", int'(pair_cnt), 0);
    chk("rst_step_last", int'(step_last), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    en = 1'b1;
    tick(1'b1, 3'd2, 3'd1, 1'b0);
    idle_wait(200);
    chk("single_pair_cnt", int'(pair_cnt), 1);

    tick(1'b1, 3'd2, 3'd1, 1'b0);
    tick(1'b1, 3'd3, 3'd6, 1'b0);
    idle_wait(300);
    chk("b2b_pair_cnt", int'(pair_cnt), 3);

    en = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b1, DW'(i + 1), DW'(7 - i), 1'b0);
    tick(1'b0, '0, '0, 1'b0);
    en = 1'b1;
    idle_wait(400);
    chk("full_pair_cnt", int'(pair_cnt), 7);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      tick($urandom_range(0, 3) == 0, DW'($urandom), DW'($urandom), $urandom_range(0, 199) == 0);
    end
    en = 1'b1;
    idle_wait(1000);

    tick(1'b1, 3'd1, 3'd2, 1'b0);
    tick(1'b1, 3'd4, 3'd5, 1'b0);
    wait_sel(2'd1);
    en = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, '0, '0, 1'b0);
      #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("enable_drop_timeout", 1, 0);
    for (int i = 0; i < 4; i++) tick(1'b1, DW'(i), DW'(i), 1'b0);
    tick(1'b0, '0, '0, 1'b1);
    en = 1'b1;
    repeat (5) tick(1'b0, '0, '0, 1'b0);

    tick(1'b1, 3'd5, 3'd3, 1'b0);
    wait_sel(2'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_sel", int'(sel), 0);
    chk("arst_din0", int'(din0), 0);
    chk("arst_din1", int'(din1), 0);
    chk("arst_step_last", int'(step_last), 0);
    chk("arst_pair_cnt", int'(pair_cnt), 0);
    chk("arst_in_ready", int'(ifc.in_ready), 1);
    sbq.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick(1'b1, 3'd7, 3'd0, 1'b0);
    idle_wait(200);
    chk("post_rst_pair_cnt", int'(pair_cnt), 1);

    en = 1'b0;
    tick(1'b0, '0, '0, 1'b0);
    h1_on = 1'b1;
    repeat (3) h1tick(1'b1, 1'b0);
    repeat (20) h1tick(1'b0, 1'b1);
    chk("h1_busy_cycles", h1_idx, 12);
    chk("h1_pair_cnt", int'(h1_pair_cnt), 3);
    h1_acc = 0;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      h1tick(h1_acc < 253, 1'b1);
      #1;
      if (h1_acc >= 253 && !h1_busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("h1_wrap_timeout", 1, 0);
    chk("h1_wrap_pair_cnt", int'(h1_pair_cnt), 0);
    chk("h1_total_cycles", h1_idx, 1024);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
